sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_rsp_fifo.sv | 74 +++++++
 rtl/sprite_rom_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite ROM arbiter
package sprite_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t KEY_COLOR = 24'hFF0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    localparam int TANK_UP    = 0;
    localparam int TANK_RIGHT = 1;
    localparam int TANK_LEFT  = 2;
    localparam int TANK_DOWN  = 3;

    // Index width that never collapses to zero bits for a single entry
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rsp_fifo.sv
// rtl/sprite_rsp_fifo.sv - response buffer with flush, occupancy count and zeroed output when empty
module sprite_rsp_fifo
    import sprite_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    // Empty FIFO presents zeros so the response outputs are clean after reset/flush
    assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sprite ROM arbiter with credit flow control (optional SPRITE_ARB_KEY_DETECT_EN)
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int                NUM_REQ    = 4,
    parameter int                ADDR_W     = 19,
    parameter int                DATA_W     = 24,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] KEY_COLOR  = DATA_W'(sprite_pkg::KEY_COLOR),
    localparam int               ID_W       = clog2_min1(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_transparent,
    output logic                      busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef SPRITE_ARB_KEY_DETECT_EN
    localparam int FIFO_W = ID_W + DATA_W + 1;
`else
    localparam int FIFO_W = ID_W + DATA_W;
`endif

    logic [1:0]         r_rst_sync;
    logic [ID_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_s1_valid;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_s2_valid;
    logic [ID_W-1:0]    r_s2_id;
    arb_state_t         r_state;

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W:0]      w_sum;
    logic               w_any;
    logic [ID_W-1:0]    w_sel;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [FIFO_W-1:0]  w_fifo_wdata;
    logic [FIFO_W-1:0]  w_fifo_rdata;
    int                 w_credit_nxt;

    // Grants wait until reset release has passed through the synchronizer
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Round-robin search: rotate requests so bit 0 is the requester at ptr
    always_comb begin : rr_search
        w_rot      = NUM_REQ'({req, req} >> r_ptr);
        w_any      = 1'b0;
        w_sum      = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && w_rot[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_ptr} + (ID_W+1)'(i);
            end
        end
        w_sel = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                              : ID_W'(w_sum);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // STALL means credit has reached the FIFO depth, so it alone blocks grants
    assign w_issue = w_any && r_rst_sync[1] && !frame_start && (r_state != ST_STALL);
    assign gnt     = w_issue ? (NUM_REQ'(1) << w_sel) : '0;
    assign w_push  = r_s2_valid && !w_full;
    assign w_pop   = rsp_valid && rsp_ready;

    // Credit one cycle ahead: new grant into S1, S1 into S2, S2 into FIFO, minus pop
    always_comb begin
        w_credit_nxt = 0;
        if (!frame_start) begin
            w_credit_nxt = int'(w_issue) + int'(r_s1_valid) + int'(w_count)
                         + int'(w_push) - int'(w_pop);
        end
    end

    // Read pipeline: S1 carries the id alongside rom_addr, S2 aligns it with rom_data
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr      <= '0;
            r_rom_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
        end else if (frame_start) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            if (w_issue) begin
                r_s1_id    <= w_sel;
                r_rom_addr <= w_sel_addr;
                r_ptr      <= (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);
            end
        end
    end

    // Occupancy state tracks the credit that will hold in the next cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else if (w_credit_nxt == 0) begin
            r_state <= ST_IDLE;
        end else if (w_credit_nxt >= FIFO_DEPTH) begin
            r_state <= ST_STALL;
        end else begin
            r_state <= ST_RUN;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign rom_addr = r_rom_addr;

`ifdef SPRITE_ARB_KEY_DETECT_EN
    assign w_fifo_wdata = {(rom_data == KEY_COLOR), r_s2_id, rom_data};
    assign {rsp_transparent, rsp_id, rsp_data} = w_fifo_rdata;
`else
    assign w_fifo_wdata = {r_s2_id, rom_data};
    assign {rsp_id, rsp_data} = w_fifo_rdata;
    assign rsp_transparent = 1'b0;
`endif

    assign rsp_valid = !w_empty;

    sprite_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .flush (frame_start),
        .push  (w_push),
        .wdata (w_fifo_wdata),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [18:0] a [4];
    logic [75:0] req_addr;
    logic [3:0]  gnt;
    logic [18:0] rom_addr;
    rgb_t        rom_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    rgb_t        rsp_data;
    logic        rsp_transparent;
    logic        busy;

    typedef struct {
        logic [1:0] id;
        rgb_t       data;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_pass = 0;
    int   n_total = 0;
    int   order [4] = '{TANK_UP, TANK_RIGHT, TANK_LEFT, TANK_DOWN};
    bit   found;

    assign req_addr = {a[3], a[2], a[1], a[0]};

    sprite_rom_arbiter dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .frame_start     (frame_start),
        .req             (req),
        .req_addr        (req_addr),
        .gnt             (gnt),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_transparent (rsp_transparent),
        .busy            (busy)
    );

    always #5 Clk = ~Clk;

    function automatic rgb_t rom_fn(input logic [18:0] ad);
        case (ad)
            19'd37:  return 24'h123456;
            19'd100: return 24'hFF0000;
            19'd101: return 24'hFF0001;
            default: return {5'd0, ad} ^ 24'h5A0000;
        endcase
    endfunction

    // Frame RAM model: one-cycle registered read
    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.id   = 2'(idx);
        e.data = rom_fn(a[idx]);
`ifdef SPRITE_ARB_KEY_DETECT_EN
        e.t = (e.data == 24'hFF0000);
`else
        e.t = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic sample_gnt(input string nm, input logic [3:0] exp);
        chk(nm, 32'(gnt), 32'(exp));
        for (int i = 0; i < 4; i++) if (exp[i]) push_exp(i);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(input int n);
        req = 4'b0000;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Monitor: compares the head of the expected queue whenever a response is shown
    always @(negedge Clk) begin
        if (Reset_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e_mon = exp_q[0];
                chk("rsp_id", 32'(rsp_id), 32'(e_mon.id));
                chk("rsp_data", 32'(rsp_data), 32'(e_mon.data));
                chk("rsp_transparent", 32'(rsp_transparent), 32'(e_mon.t));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) a[i] = '0;
        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_transparent", 32'(rsp_transparent), 0);
        chk("rst_busy", 32'(busy), 0);
        cyc();
        Reset_n = 1'b1;
        repeat (3) cyc();

        // Single request latency
        req = 4'b0001; a[0] = 19'd37; rsp_ready = 1'b1;
        @(negedge Clk); sample_gnt("single_gnt", 4'(1 << TANK_UP));
        cyc(); req = 4'b0000;
        @(negedge Clk);
        chk("single_rom_addr", 32'(rom_addr), 37);
        chk("single_busy", 32'(busy), 1);
        sample_gnt("single_gnt_off", 4'b0000);
        cyc(); @(negedge Clk); chk("single_valid_t2", 32'(rsp_valid), 0);
        cyc(); @(negedge Clk); chk("single_valid_t3", 32'(rsp_valid), 1);
        cyc(); @(negedge Clk); chk("single_idle", 32'(busy), 0);
        cyc();

        // frame_start suppresses grants and resets ptr
        frame_start = 1'b1; req = 4'b1111;
        @(negedge Clk); sample_gnt("fs_gnt_suppress", 4'b0000);
        cyc(); frame_start = 1'b0;

        // Contention with rsp_ready high
        for (int i = 0; i < 4; i++) a[i] = 19'(10 + i);
        for (int c = 0; c < 12; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge Clk);
            sample_gnt("cont_gnt", (c < 8) ? 4'(1 << order[c % 4]) : 4'b0000);
            if (c >= 3 && c <= 10) chk("cont_no_gap", 32'(rsp_valid), 1);
            if (c == 11) chk("cont_idle", 32'(busy), 0);
            cyc();
        end

        // Backpressure: four grants then STALL, resume once drained
        for (int i = 0; i < 4; i++) a[i] = 19'(20 + i);
        rsp_ready = 1'b0; req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            sample_gnt("bp_gnt", (c < 4) ? 4'(1 << c) : 4'b0000);
            if (c >= 4) chk("bp_busy", 32'(busy), 1);
            cyc();
        end
        rsp_ready = 1'b1;
        for (int c = 8; c < 13; c++) begin
            @(negedge Clk);
            sample_gnt("bp_resume_gnt", (c == 8) ? 4'b0000 : 4'(1 << (c - 9)));
            cyc();
        end
        drain(6);
        @(negedge Clk); chk("bp_idle", 32'(busy), 0);
        cyc();

        // Flush with two reads in flight and one buffered
        for (int i = 0; i < 4; i++) a[i] = 19'(30 + i);
        rsp_ready = 1'b0; req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk); sample_gnt("fl_gnt", 4'(1 << c));
            cyc();
        end
        frame_start = 1'b1;
        @(negedge Clk);
        sample_gnt("fl_gnt_suppress", 4'b0000);
        chk("fl_busy_before", 32'(busy), 1);
        cyc();
        exp_q.delete();
        frame_start = 1'b0;
        @(negedge Clk);
        chk("fl_rsp_valid", 32'(rsp_valid), 0);
        chk("fl_busy", 32'(busy), 0);
        sample_gnt("fl_regrant", 4'(1 << TANK_UP));
        cyc();
        rsp_ready = 1'b1;
        drain(5);

        // Key color detection
        req = 4'b0001; a[0] = 19'd100;
        @(negedge Clk); sample_gnt("key_gnt_a", 4'b0001);
        cyc(); a[0] = 19'd101;
        @(negedge Clk); sample_gnt("key_gnt_b", 4'b0001);
        cyc();
        drain(5);

        // Reset pulse during contention
        for (int i = 0; i < 4; i++) a[i] = 19'(40 + i);
        req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            sample_gnt("mr_gnt", 4'(1 << ((c + 1) % 4)));
            cyc();
        end
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("mr_gnt0", 32'(gnt), 0);
        chk("mr_rom_addr0", 32'(rom_addr), 0);
        chk("mr_rsp_valid0", 32'(rsp_valid), 0);
        chk("mr_rsp_id0", 32'(rsp_id), 0);
        chk("mr_rsp_data0", 32'(rsp_data), 0);
        chk("mr_rsp_transparent0", 32'(rsp_transparent), 0);
        chk("mr_busy0", 32'(busy), 0);
        cyc();
        exp_q.delete();
        Reset_n = 1'b1;
        @(negedge Clk); chk("mr_sync_gnt", 32'(gnt), 0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            cyc();
            @(negedge Clk);
            if (gnt != 4'b0000) found = 1'b1;
        end
        sample_gnt("mr_first_gnt", 4'b0001);
        cyc();
        drain(6);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("final_busy", 32'(busy), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
